// File: rtl/bram_operand_fetch.sv
// Operand fetch sequencer: walks C = A x B index space, issues paired bram reads
// and streams (a, b, last) pairs to the MAC stage. Tag sidebands under FETCH_TAG_EN.
module bram_operand_fetch #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N          = 2,
  parameter int unsigned A_BASE     = 0,
  parameter int unsigned B_BASE     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    en_a,
  output logic                    we_a,
  output logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   dout_a,
  output logic                    en_b,
  output logic                    we_b,
  output logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   dout_b,
  output logic                    op_valid,
  input  logic                    op_ready,
  output logic [DATA_WIDTH-1:0]   op_a,
  output logic [DATA_WIDTH-1:0]   op_b,
  output logic                    op_last
`ifdef FETCH_TAG_EN
  ,
  output logic [$clog2(N)-1:0]    op_row,
  output logic [$clog2(N)-1:0]    op_col
`endif
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
  logic                    en_q, en_d;
  logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic                    iss_last_q, iss_last_d;
  logic                    rv_q, rv_d, rv_last_q, rv_last_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic [DATA_WIDTH-1:0]   mem_a_q [2];
  logic [DATA_WIDTH-1:0]   mem_a_d [2];
  logic [DATA_WIDTH-1:0]   mem_b_q [2];
  logic [DATA_WIDTH-1:0]   mem_b_d [2];
  logic [1:0]              mem_last_q, mem_last_d;
  logic                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]              cnt_q, cnt_d;
`ifdef FETCH_TAG_EN
  logic [IDX_W-1:0]        iss_row_q, iss_row_d, iss_col_q, iss_col_d;
  logic [IDX_W-1:0]        rv_row_q, rv_row_d, rv_col_q, rv_col_d;
  logic [IDX_W-1:0]        mem_row_q [2];
  logic [IDX_W-1:0]        mem_row_d [2];
  logic [IDX_W-1:0]        mem_col_q [2];
  logic [IDX_W-1:0]        mem_col_d [2];
`endif

  logic                    push, pop, do_issue;
  logic [IDX_W-1:0]        cur_i, cur_j, cur_k;

  // The head is the FIFO entry if any, else the read landing this cycle (bypass).
  assign op_valid = (cnt_q != 2'd0) | rv_q;
  assign op_a     = (cnt_q != 2'd0) ? mem_a_q[rd_ptr_q] : (rv_q ? dout_a : '0);
  assign op_b     = (cnt_q != 2'd0) ? mem_b_q[rd_ptr_q] : (rv_q ? dout_b : '0);
  assign op_last  = (cnt_q != 2'd0) ? mem_last_q[rd_ptr_q] : (rv_q & rv_last_q);
`ifdef FETCH_TAG_EN
  assign op_row   = (cnt_q != 2'd0) ? mem_row_q[rd_ptr_q] : (rv_q ? rv_row_q : '0);
  assign op_col   = (cnt_q != 2'd0) ? mem_col_q[rd_ptr_q] : (rv_q ? rv_col_q : '0);
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign en_a   = en_q;
  assign en_b   = en_q;
  assign we_a   = 1'b0;
  assign we_b   = 1'b0;
  assign addr_a = addr_a_q;
  assign addr_b = addr_b_q;

  // Next-state, FIFO bookkeeping and issue control
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    en_d       = 1'b0;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    iss_last_d = iss_last_q;
    rv_d       = en_q;
    rv_last_d  = iss_last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mem_a_d    = mem_a_q;
    mem_b_d    = mem_b_q;
    mem_last_d = mem_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    do_issue   = 1'b0;
    cur_i      = i_q;
    cur_j      = j_q;
    cur_k      = k_q;
`ifdef FETCH_TAG_EN
    iss_row_d  = iss_row_q;
    iss_col_d  = iss_col_q;
    rv_row_d   = iss_row_q;
    rv_col_d   = iss_col_q;
    mem_row_d  = mem_row_q;
    mem_col_d  = mem_col_q;
`endif

    pop  = (cnt_q != 2'd0) & op_ready;
    push = rv_q & ~((cnt_q == 2'd0) & op_ready);
    if (push) begin
      mem_a_d[wr_ptr_q]    = dout_a;
      mem_b_d[wr_ptr_q]    = dout_b;
      mem_last_d[wr_ptr_q] = rv_last_q;
`ifdef FETCH_TAG_EN
      mem_row_d[wr_ptr_q]  = rv_row_q;
      mem_col_d[wr_ptr_q]  = rv_col_q;
`endif
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ISSUE;
          busy_d   = 1'b1;
          cur_i    = '0;
          cur_j    = '0;
          cur_k    = '0;
          do_issue = 1'b1;
        end
      end
      S_ISSUE: begin
        // Credit: stored entries plus the read landing next cycle must leave room.
        if ((cnt_d + 2'(en_q)) < 2'd2) do_issue = 1'b1;
      end
      S_DRAIN: begin
        if ((cnt_d == 2'd0) && !en_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_issue) begin
      en_d       = 1'b1;
      addr_a_d   = ADDR_WIDTH'(A_BASE) + ADDR_WIDTH'(cur_i) * ADDR_WIDTH'(N) + ADDR_WIDTH'(cur_k);
      addr_b_d   = ADDR_WIDTH'(B_BASE) + ADDR_WIDTH'(cur_k) * ADDR_WIDTH'(N) + ADDR_WIDTH'(cur_j);
      iss_last_d = (cur_k == IDX_W'(N - 1));
`ifdef FETCH_TAG_EN
      iss_row_d  = cur_i;
      iss_col_d  = cur_j;
`endif
      i_d = cur_i;
      j_d = cur_j;
      k_d = cur_k + IDX_W'(1);
      if (cur_k == IDX_W'(N - 1)) begin
        k_d = '0;
        j_d = cur_j + IDX_W'(1);
        if (cur_j == IDX_W'(N - 1)) begin
          j_d = '0;
          i_d = cur_i + IDX_W'(1);
          if (cur_i == IDX_W'(N - 1)) begin
            i_d     = '0;
            state_d = S_DRAIN;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      en_q       <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      iss_last_q <= 1'b0;
      rv_q       <= 1'b0;
      rv_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_a_q    <= '{default: '0};
      mem_b_q    <= '{default: '0};
      mem_last_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
`ifdef FETCH_TAG_EN
      iss_row_q  <= '0;
      iss_col_q  <= '0;
      rv_row_q   <= '0;
      rv_col_q   <= '0;
      mem_row_q  <= '{default: '0};
      mem_col_q  <= '{default: '0};
`endif
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      en_q       <= en_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      iss_last_q <= iss_last_d;
      rv_q       <= rv_d;
      rv_last_q  <= rv_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_a_q    <= mem_a_d;
      mem_b_q    <= mem_b_d;
      mem_last_q <= mem_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
`ifdef FETCH_TAG_EN
      iss_row_q  <= iss_row_d;
      iss_col_q  <= iss_col_d;
      rv_row_q   <= rv_row_d;
      rv_col_q   <= rv_col_d;
      mem_row_q  <= mem_row_d;
      mem_col_q  <= mem_col_d;
`endif
    end
  end

endmodule

// File: tb/tb_bram_operand_fetch.sv
// Directed bench for bram_operand_fetch (N=2) with a behavioural synchronous-read bram.
module tb_bram_operand_fetch;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 2;

  logic          clk = 1'b0;
  logic          rst_n, start, op_ready;
  logic          busy, done, en_a, we_a, en_b, we_b, op_valid, op_last;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] dout_a, dout_b, op_a, op_b;
`ifdef FETCH_TAG_EN
  logic [0:0]    op_row, op_col;
`endif

  logic [DW-1:0] mem [16];
  logic [DW-1:0] exp_a [8];
  logic [DW-1:0] exp_b [8];
  logic          exp_last [8];
  logic [AW-1:0] exp_aa [8];
  logic [AW-1:0] exp_ab [8];
  logic [0:0]    exp_row [8];
  logic [0:0]    exp_col [8];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_idx, iss_idx, done_cnt;
  int first_en, first_valid, first_hs, last_hs, done_cyc;
  logic          held, held_last;
  logic [DW-1:0] held_a, held_b;

  bram_operand_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N(N), .A_BASE(0), .B_BASE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .dout_a(dout_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .dout_b(dout_b),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_last(op_last)
`ifdef FETCH_TAG_EN
    , .op_row(op_row), .op_col(op_col)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read bram: data one cycle after en, holds while en is low
  always @(posedge clk) begin
    if (en_a) dout_a <= mem[addr_a];
    if (en_b) dout_b <= mem[addr_b];
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    hs_idx = 0; iss_idx = 0; done_cnt = 0; held = 1'b0;
    first_en = -1; first_valid = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
  endtask

  // One cycle: check at the falling edge, then return 1 time unit after the rising edge
  task automatic sample();
    @(negedge clk);
    cyc++;
    chk("we_tied_low", 72'({we_a, we_b}), 72'(0));
    if (en_a || en_b) begin
      chk("en_pair", 72'({en_a, en_b}), 72'(2'b11));
      if (iss_idx < 8) chk("issue_addr", 72'({addr_a, addr_b}), 72'({exp_aa[iss_idx], exp_ab[iss_idx]}));
      else chk("extra_issue", 72'(iss_idx), 72'(7));
      chk("credit", 72'((iss_idx + 1 - hs_idx) <= 2), 72'(1));
      if (first_en < 0) first_en = cyc;
      iss_idx++;
    end
    if (held) chk("stall_hold", 72'({op_valid, op_last, op_a, op_b}), 72'({1'b1, held_last, held_a, held_b}));
    if (op_valid && first_valid < 0) first_valid = cyc;
    if (op_valid && op_ready) begin
      if (hs_idx < 8) begin
        chk("pair_data", 72'({op_a, op_b}), 72'({exp_a[hs_idx], exp_b[hs_idx]}));
        chk("pair_last", 72'(op_last), 72'(exp_last[hs_idx]));
`ifdef FETCH_TAG_EN
        chk("pair_tag", 72'({op_row, op_col}), 72'({exp_row[hs_idx], exp_col[hs_idx]}));
`endif
      end else chk("extra_pair", 72'(hs_idx), 72'(7));
      if (hs_idx == 0) first_hs = cyc;
      last_hs = cyc;
      hs_idx++;
    end
    held = op_valid && !op_ready;
    held_a = op_a; held_b = op_b; held_last = op_last;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_low_at_done", 72'(busy), 72'(0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(tag, 72'({busy, done, en_a, en_b, op_valid, op_last}), 72'(0));
    chk({tag, "_data"}, 72'({op_a, op_b}), 72'(0));
    chk({tag, "_addr"}, 72'({addr_a, addr_b}), 72'(0));
  endtask

  // mode 0: ready high; 1: ready 1,0,0 pattern; 2: re-start at pair 3; 3: reset after pair 4
  task automatic run_pass(input int mode);
    int start_cyc;
    int t;
    bit restarted;
    reset_model();
    restarted = 1'b0;
    op_ready = 1'b1;
    start = 1'b1;
    start_cyc = cyc + 1;
    sample();
    start = 1'b0;
    chk("busy_after_start", 72'(busy), 72'(1));
    t = 0;
    while (done_cnt == 0 && t < 80) begin
      op_ready = (mode == 1) ? ((t % 3) == 0) : 1'b1;
      if (mode == 2 && hs_idx == 3 && !restarted) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      sample();
      start = 1'b0;
      t++;
      if (mode == 3 && hs_idx == 4) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_pass_reset");
        chk("no_done_on_abort", 72'(done_cnt), 72'(0));
        #2;
        rst_n = 1'b1;
        return;
      end
    end
    chk("done_seen", 72'(done_cnt), 72'(1));
    chk("done_after_last_hs", 72'(done_cyc), 72'(last_hs + 1));
    if (mode == 0) begin
      chk("first_issue_latency", 72'(first_en), 72'(start_cyc + 1));
      chk("first_valid_latency", 72'(first_valid), 72'(start_cyc + 2));
      chk("back_to_back", 72'(last_hs - first_hs), 72'(7));
    end
    op_ready = 1'b1;
    repeat (5) sample();
    chk("done_once", 72'(done_cnt), 72'(1));
    chk("pair_count", 72'(hs_idx), 72'(8));
    chk("issue_count", 72'(iss_idx), 72'(8));
    chk("idle_after_pass", 72'({busy, op_valid, en_a}), 72'(0));
  endtask

  initial begin
    for (int w = 0; w < 16; w++) mem[w] = 32'hDEADBEEF;
    mem[0] = 32'h3F800000; mem[1] = 32'h40000000; mem[2] = 32'h40400000; mem[3] = 32'h40800000;
    mem[4] = 32'h40A00000; mem[5] = 32'h40C00000; mem[6] = 32'h40E00000; mem[7] = 32'h41000000;
    exp_a    = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000,
                 32'h40400000, 32'h40800000, 32'h40400000, 32'h40800000};
    exp_b    = '{32'h40A00000, 32'h40E00000, 32'h40C00000, 32'h41000000,
                 32'h40A00000, 32'h40E00000, 32'h40C00000, 32'h41000000};
    exp_last = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_aa   = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd3};
    exp_ab   = '{4'd4, 4'd6, 4'd5, 4'd7, 4'd4, 4'd6, 4'd5, 4'd7};
    exp_row  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_col  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; op_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    repeat (2) sample();

    run_pass(0);
    run_pass(1);
    run_pass(2);
    run_pass(3);
    run_pass(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bram_operand_fetch.md
Name: bram_operand_fetch

Overview:
- Sequencer directly downstream of the dual-port bram. Walks the index space of C = A x B and issues paired reads: A on port A, B on port B.
- Streams (a, b) operand pairs with a last-of-dot-product flag into the FP multiply-accumulate stage over valid/ready.
- Both square matrices (N x N, row-major, 32-bit IEEE-754) live in one bram instance at A_BASE and B_BASE.

Parameters:
- ADDR_WIDTH, 4: bram address width; must match the bram instance.
- DATA_WIDTH, 32: operand width.
- N, 2: matrix dimension. Legal range 2..16. Requires A_BASE+N*N and B_BASE+N*N <= 2^ADDR_WIDTH.
- A_BASE, 0: word address of A[0][0].
- B_BASE, 4: word address of B[0][0].

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a full C pass when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final pair handshakes.
- en_a  out  1  bram port A enable.
- we_a  out  1  bram port A write enable; tied 0.
- addr_a  out  ADDR_WIDTH  bram port A address.
- dout_a  in  DATA_WIDTH  bram port A read data.
- en_b  out  1  bram port B enable.
- we_b  out  1  bram port B write enable; tied 0.
- addr_b  out  ADDR_WIDTH  bram port B address.
- dout_b  in  DATA_WIDTH  bram port B read data.
- op_valid  out  1  operand pair valid.
- op_ready  in  1  MAC stage accepts the pair.
- op_a  out  DATA_WIDTH  A[i][k].
- op_b  out  DATA_WIDTH  B[k][j].
- op_last  out  1  high when k == N-1.
- op_row  out  $clog2(N)  i; present only with FETCH_TAG_EN.
- op_col  out  $clog2(N)  j; present only with FETCH_TAG_EN.

Behaviour:
- Reset, asynchronous: busy=0, done=0, en_a=en_b=0, addr_a=addr_b=0, op_valid=0, op_a=op_b=0, op_last=0, tags=0, i=j=k=0, buffer empty, state IDLE.
- Bram contract: synchronous read, data valid 1 cycle after en=1. dout holds while en=0.
- FSM has four states:
  - IDLE: start=1 moves to ISSUE and clears i, j, k.
  - ISSUE: each cycle where (buffer count + reads in flight) < 2, drive en_a=en_b=1, addr_a=A_BASE+i*N+k and addr_b=B_BASE+k*N+j. Otherwise en=0.
  - ISSUE advance: k increments; at k=N-1 it wraps to 0 and j increments; at j=N-1 it wraps to 0 and i increments. After issuing (N-1, N-1, N-1), go to DRAIN.
  - DRAIN: no issues. When the buffer is empty and nothing is in flight, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- The returning read is captured, one cycle after issue, into a 2-entry FIFO together with last and tag sidebands.
- Credit rule: the FIFO never overflows. With op_ready held high, throughput is one pair per cycle.
- Output signals are driven from the FIFO head. A pair transfers on op_valid & op_ready.
- Once op_valid rises, op_a, op_b, op_last and the tags hold stable until handshake.
- Latency: start in cycle 0, first issue in cycle 1, op_valid in cycle 2 with op_ready high.
- Total pairs per pass: N^3, in order i, j, k with k innermost.
- Address arithmetic is done at ADDR_WIDTH bits and truncates. Parameter legality guarantees no wrap.
- start while busy: ignored, no restart.
- start and done in the same cycle: start is ignored.
- op_ready low for many cycles: issues stop once credit is exhausted. No pair is lost or duplicated.
- Reset mid-pass: immediate abort, all outputs return to reset values, no done pulse.
- busy falls in the same cycle done pulses.

Optional Feature:
- Macro FETCH_TAG_EN.
- Defined: op_row and op_col exist, carry i and j for every pair, and travel through the FIFO with the data.
- Undefined: the ports and their FIFO storage are absent. All other behaviour is identical.

Test Plan:
- Test data, N=2, A_BASE=0, B_BASE=4:
  - A = 3F800000, 40000000, 40400000, 40800000 (1,2,3,4).
  - B = 40A00000, 40C00000, 40E00000, 41000000 (5,6,7,8).
- Preload the test data, pulse start, hold op_ready=1 -> 8 pairs on consecutive cycles:
  - (3F800000,40A00000,last0), (40000000,40E00000,last1)
  - (3F800000,40C00000,last0), (40000000,41000000,last1)
  - (40400000,40A00000,last0), (40800000,40E00000,last1)
  - (40400000,40C00000,last0), (40800000,41000000,last1)
  - done pulses one cycle after the 8th handshake.
- Same data, op_ready toggling 1,0,0,1,... -> identical 8-pair sequence. Outputs stable while stalled. en_a never asserted with 2 credits consumed.
- Pulse start again while busy at pair 3 -> sequence unaffected, exactly one done.
- Deassert rst_n after pair 4 -> op_valid=0, en_a=en_b=0, busy=0 immediately. A new start reproduces the full sequence from pair 1.
- FETCH_TAG_EN defined -> (op_row, op_col) = 0/0, 0/0, 0/1, 0/1, 1/0, 1/0, 1/1, 1/1.
- Across all tests -> we_a=we_b=0 throughout, and addr_a/addr_b match A_BASE+i*N+k / B_BASE+k*N+j on every issue.
